// File: rtl/neuron_ctrl_pkg.sv
// Shared definitions for the neuron sequencer and the layer scheduler that paces it.
// NEURON_LAT is the start-accept to done distance in cycles for the default neuron size.
package neuron_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_MAC   = 3'd2,
      S_BIAS  = 3'd3,
      S_ACT   = 3'd4
   } state_t;

   localparam int N_DEFAULT = 10;

   function automatic int neuron_lat(input int n);
      return n + 3;
   endfunction

   localparam int NEURON_LAT = neuron_lat(N_DEFAULT);

endpackage

// File: rtl/mac_index_counter.sv
// Weight/input index for the MAC phase: counts 0..N-1 while enabled, flags N-1.
// One-cycle registered update; clear has priority over enable and never lets the count pass N-1.
module mac_index_counter #(
   parameter int N  = 10,
   parameter int OW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          en_i,
   output logic [OW-1:0] cnt_o,
   output logic          tc_o
);

   localparam logic [OW-1:0] LAST = OW'(N - 1);

   logic [OW-1:0] cnt_q;
   logic [OW-1:0] cnt_d;

   // Explicit wrap at LAST keeps non-power-of-2 N inside 0..N-1 even if enable is held.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + OW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == LAST);

endmodule

// File: rtl/neuron_controller.sv
// Sequencer for one neuron datapath: clear, N MAC steps, bias add, activation; done N+3 cycles after accept.
// start is only honoured in IDLE/ACT and is dropped (not queued) while an evaluation is in flight.
module neuron_controller
   import neuron_ctrl_pkg::*;
#(
   parameter int N  = 10,
   parameter int OW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          hidden_in,
   output logic          busy,
   output logic          done,
   output logic [OW-1:0] offset,
   output logic          ld,
   output logic          clr,
   output logic          mult_done,
   output logic          ready,
   output logic          hidden
);

   state_t state_q;
   state_t state_d;
   logic   hidden_q;
   logic   busy_q;
   logic   done_q;
   logic   ld_q;
   logic   clr_q;
   logic   mult_done_q;
   logic   ready_q;

   logic   accept;
   logic   cnt_clr;
   logic   cnt_en;
   logic   cnt_tc;

   assign accept  = start && ((state_q == S_IDLE) || (state_q == S_ACT));
   assign cnt_en  = (state_q == S_MAC);
   assign cnt_clr = (state_q != S_MAC) || cnt_tc;

   mac_index_counter #(
      .N  (N),
      .OW (OW)
   ) u_idx (
      .clk   (clk),
      .rst   (rst),
      .clr_i (cnt_clr),
      .en_i  (cnt_en),
      .cnt_o (offset),
      .tc_o  (cnt_tc)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_CLEAR;
         S_CLEAR: state_d = S_MAC;
         S_MAC:   if (cnt_tc) state_d = S_BIAS;
         S_BIAS:  state_d = S_ACT;
         S_ACT:   state_d = accept ? S_CLEAR : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with state_q one edge later.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         hidden_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ld_q        <= 1'b0;
         clr_q       <= 1'b0;
         mult_done_q <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         if (accept) begin
            hidden_q <= hidden_in;
         end
         busy_q      <= (state_d != S_IDLE);
         done_q      <= (state_d == S_ACT);
         ld_q        <= (state_d == S_MAC) || (state_d == S_BIAS);
         clr_q       <= (state_d == S_CLEAR);
         mult_done_q <= (state_d == S_BIAS);
         // ready stays up through IDLE so the datapath result remains qualified.
         if (state_d == S_ACT) begin
            ready_q <= 1'b1;
         end else if (state_d == S_CLEAR) begin
            ready_q <= 1'b0;
         end
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign ld        = ld_q;
   assign clr       = clr_q;
   assign mult_done = mult_done_q;
   assign ready     = ready_q;
   assign hidden    = hidden_q;

endmodule

// File: tb/tb_neuron_controller.sv
// Two sequencers (N=10 and N=3) driven by shared directed+random stimulus, checked against a timeline model.
// A small accumulator stands in for the neuron datapath so each done also checks the computed result.
module tb_neuron_controller;

   localparam int MAXC = 2048;
   localparam int INP  = 1;
   localparam int WGT  = 2;
   localparam int BIAS = 0;

   typedef struct packed {
      logic       busy;
      logic       clr;
      logic       ld;
      logic       md;
      logic       done;
      logic       rdy;
      logic       hid;
      logic [8:0] off;
   } obs_t;

   typedef struct {
      int   cyc;
      logic hid;
      int   res;
   } sb_t;

   logic clk;
   logic rst;
   logic start;
   logic hidden_in;

   logic       busy_a, done_a, ld_a, clr_a, md_a, rdy_a, hid_a;
   logic [3:0] off_a;
   logic       busy_b, done_b, ld_b, clr_b, md_b, rdy_b, hid_b;
   logic [1:0] off_b;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   next_free [2];
   int   acc [2];
   obs_t exp_tl [2][MAXC];
   sb_t  sbq [2][$];
   logic final_chk = 1'b0;
   logic final_done = 1'b0;

   neuron_controller #(.N(10), .OW(4)) dut_a (
      .clk(clk), .rst(rst), .start(start), .hidden_in(hidden_in),
      .busy(busy_a), .done(done_a), .offset(off_a), .ld(ld_a), .clr(clr_a),
      .mult_done(md_a), .ready(rdy_a), .hidden(hid_a)
   );

   neuron_controller #(.N(3), .OW(2)) dut_b (
      .clk(clk), .rst(rst), .start(start), .hidden_in(hidden_in),
      .busy(busy_b), .done(done_b), .offset(off_b), .ld(ld_b), .clr(clr_b),
      .mult_done(md_b), .ready(rdy_b), .hidden(hid_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int golden(input int n);
      int s = BIAS;
      for (int i = 0; i < n; i++) s += INP * WGT;
      return s;
   endfunction

   // Behavioural stand-in for the neuron datapath accumulator.
   task automatic dp_step(input int i, input int n, input logic c, input logic l,
                          input logic m, input logic [8:0] o);
      if (c === 1'b1) acc[i] = 0;
      else if (l === 1'b1) begin
         if (m === 1'b1) acc[i] = acc[i] + BIAS;
         else if (int'(o) < n) acc[i] = acc[i] + INP * WGT;
      end
   endtask

   // Expected timeline: reset blanks everything after the edge; an accept lays out one whole run.
   task automatic model_step(input int i, input int n, input int c);
      sb_t  keep [$];
      sb_t  e;
      obs_t o;
      if (rst === 1'b1) begin
         for (int t = c + 1; t < MAXC; t++) exp_tl[i][t] = '0;
         for (int k = 0; k < sbq[i].size(); k++)
            if (sbq[i][k].cyc <= c) keep.push_back(sbq[i][k]);
         sbq[i] = keep;
         next_free[i] = c + 1;
      end else if (start === 1'b1 && c >= next_free[i]) begin
         for (int t = c + 1; t < MAXC; t++) begin
            o      = '0;
            o.busy = (t <= c + n + 3);
            o.clr  = (t == c + 1);
            o.ld   = (t >= c + 2) && (t <= c + n + 2);
            o.md   = (t == c + n + 2);
            o.done = (t == c + n + 3);
            o.rdy  = (t >= c + n + 3);
            o.hid  = hidden_in;
            if (t >= c + 2 && t <= c + n + 1) o.off = 9'(t - c - 2);
            exp_tl[i][t] = o;
         end
         e.cyc = c + n + 3;
         e.hid = hidden_in;
         e.res = golden(n);
         sbq[i].push_back(e);
         next_free[i] = c + n + 3;
      end
   endtask

   always @(posedge clk) begin
      dp_step(0, 10, clr_a, ld_a, md_a, 9'(off_a));
      dp_step(1, 3, clr_b, ld_b, md_b, 9'(off_b));
      if (cyc < MAXC) begin
         model_step(0, 10, cyc);
         model_step(1, 3, cyc);
      end
   end

   task automatic check_inst(input int i, input obs_t act);
      sb_t s;
      n_checks++;
      if (act !== exp_tl[i][cyc]) begin
         n_errors++;
         $display("FAIL outputs inst%0d cyc %0d: got %h expected %h", i, cyc, act, exp_tl[i][cyc]);
      end
      if (act.done === 1'b1) begin
         n_checks++;
         if (sbq[i].size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_done inst%0d cyc %0d: got done=1 expected no pending run", i, cyc);
         end else begin
            s = sbq[i].pop_front();
            if (s.cyc != cyc || act.hid !== s.hid || acc[i] != s.res) begin
               n_errors++;
               $display("FAIL done_event inst%0d: got cyc %0d hidden %b result %0d expected cyc %0d hidden %b result %0d",
                        i, cyc, act.hid, acc[i], s.cyc, s.hid, s.res);
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (cyc >= 1 && cyc < MAXC) begin
         check_inst(0, {busy_a, clr_a, ld_a, md_a, done_a, rdy_a, hid_a, 9'(off_a)});
         check_inst(1, {busy_b, clr_b, ld_b, md_b, done_b, rdy_b, hid_b, 9'(off_b)});
      end
      if (final_chk && !final_done) begin
         final_done = 1'b1;
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (sbq[i].size() != 0) begin
               n_errors++;
               $display("FAIL missing_done inst%0d: got %0d runs without done, expected 0", i, sbq[i].size());
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; hidden_in = 1'b0;
      tick(2);
      rst = 1'b0;
      // single run
      start = 1'b1; tick(1); start = 1'b0; tick(15);
      // hidden=1 at accept, stray starts and hidden toggles during the run
      start = 1'b1; hidden_in = 1'b1; tick(1);
      for (int k = 1; k <= 14; k++) begin
         start = (k == 3 || k == 7 || k == 11);
         hidden_in = k[0];
         tick(1);
      end
      start = 1'b1; hidden_in = 1'b0; tick(1); start = 1'b0; tick(14);
      // back-to-back
      start = 1'b1; tick(40); start = 1'b0; tick(14);
      // reset lands while the N=10 instance is at offset 4
      start = 1'b1; tick(1); start = 1'b0; tick(5);
      rst = 1'b1; tick(2); rst = 1'b0; tick(20);
      // random traffic
      for (int k = 0; k < 1400; k++) begin
         rst       = ($urandom_range(0, 199) == 0);
         start     = ($urandom_range(0, 2) == 0);
         hidden_in = 1'($urandom_range(0, 1));
         tick(1);
      end
      rst = 1'b0; start = 1'b0; tick(20);
      final_chk = 1'b1;
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
